// File: rtl/umtrx_async_msg_framer_if.sv
// Output stream of the async message framer: 36-bit words with SOF/EOF flags
// and a valid/ready handshake toward the router's output combiner.
interface umtrx_async_msg_framer_if;
  logic [35:0] o_data;
  logic        o_valid;
  logic        o_ready;

  modport master (output o_data, output o_valid, input o_ready);
  modport slave  (input o_data, input o_valid, output o_ready);
endinterface

// File: rtl/umtrx_async_msg_framer.sv
// Queues TX-path events and frames each one as a 6-word VRT ext-context packet.
// Optional saturating drop counter reported in W5: `define UMTRX_ASYNC_DROP_CNT_EN.
module umtrx_async_msg_framer #(
  parameter int BASE  = 0,
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        set_stb,
  input  logic [7:0]  set_addr,
  input  logic [31:0] set_data,
  input  logic        evt_stb,
  input  logic [31:0] evt_code,
  input  logic [63:0] evt_time,
  umtrx_async_msg_framer_if.master src
);
  localparam int             ENTRIES = 1 << DEPTH;
  localparam logic [DEPTH:0] PTR_ONE = 1;

  typedef enum logic [2:0] {IDLE, W0, W1, W2, W3, W4, W5} state_t;

  state_t         state;
  logic [31:0]    sid;
  logic           enable;
  logic [95:0]    mem [ENTRIES];
  logic [DEPTH:0] wr_ptr;
  logic [DEPTH:0] rd_ptr;
  logic [DEPTH:0] level;
  logic           full;
  logic           empty;
  logic           push;
  logic           pop;
  logic           accept;
  logic [95:0]    head;
  logic [3:0]     seq;
  logic [3:0]     w0_seq;
  logic [35:0]    w0_word;
  logic [31:0]    cur_code;
  logic [63:0]    cur_time;
  logic [31:0]    w5_payload;

  always_ff @(posedge clk) begin
    if (reset) begin
      sid    <= '0;
      enable <= 1'b0;
    end else if (set_stb) begin
      if (set_addr == 8'(BASE))     sid    <= set_data;
      if (set_addr == 8'(BASE + 1)) enable <= set_data[0];
    end
  end

  assign level   = wr_ptr - rd_ptr;
  assign full    = level[DEPTH];
  assign empty   = (level == '0);
  assign push    = evt_stb & enable & ~full;
  assign accept  = src.o_valid & src.o_ready;
  assign pop     = ~empty & ((state == IDLE) | ((state == W5) & accept));
  assign head    = mem[rd_ptr[DEPTH-1:0]];
  // When chaining out of W5 the new header must carry the already-advanced seq.
  assign w0_seq  = (state == W5) ? seq + 4'd1 : seq;
  assign w0_word = {4'b0001, 4'h5, 4'h0, 2'b00, 2'b01, w0_seq, 16'd6};

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[DEPTH-1:0]] <= {evt_code, evt_time};
  end

  always_ff @(posedge clk) begin
    if (reset || clear) wr_ptr <= '0;
    else if (push)      wr_ptr <= wr_ptr + PTR_ONE;
  end

`ifdef UMTRX_ASYNC_DROP_CNT_EN
  logic [15:0] drops;
  logic        drop;
  logic        sample;

  assign drop   = evt_stb & enable & full;
  assign sample = (state == W4) & accept;

  always_ff @(posedge clk) begin
    if (reset || clear)                drops <= '0;
    else if (sample)                   drops <= {15'd0, drop};
    else if (drop && (drops != '1))    drops <= drops + 16'd1;
  end

  assign w5_payload = {16'd0, drops};
`else
  assign w5_payload = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state       <= IDLE;
      src.o_valid <= 1'b0;
      src.o_data  <= '0;
      rd_ptr      <= '0;
      seq         <= '0;
      cur_code    <= '0;
      cur_time    <= '0;
    end else begin
      if (pop) begin
        rd_ptr   <= rd_ptr + PTR_ONE;
        cur_code <= head[95:64];
        cur_time <= head[63:0];
      end
      unique case (state)
        IDLE: if (pop) begin
          state       <= W0;
          src.o_valid <= 1'b1;
          src.o_data  <= w0_word;
        end
        W0: if (accept) begin
          state      <= W1;
          src.o_data <= {4'b0000, sid};
        end
        W1: if (accept) begin
          state      <= W2;
          src.o_data <= {4'b0000, cur_time[63:32]};
        end
        W2: if (accept) begin
          state      <= W3;
          src.o_data <= {4'b0000, cur_time[31:0]};
        end
        W3: if (accept) begin
          state      <= W4;
          src.o_data <= {4'b0000, cur_code};
        end
        W4: if (accept) begin
          state      <= W5;
          src.o_data <= {4'b0010, w5_payload};
        end
        W5: if (accept) begin
          seq <= seq + 4'd1;
          if (pop) begin
            state      <= W0;
            src.o_data <= w0_word;
          end else begin
            state       <= IDLE;
            src.o_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_umtrx_async_msg_framer.sv
// Self-checking bench for umtrx_async_msg_framer: vector table plus scoreboard,
// with hand-written sequences for overflow, backpressure, abort and disable.
module tb_umtrx_async_msg_framer;
  logic        clk = 1'b0;
  logic        reset;
  logic        clear;
  logic        set_stb;
  logic [7:0]  set_addr;
  logic [31:0] set_data;
  logic        evt_stb;
  logic [31:0] evt_code;
  logic [63:0] evt_time;

  umtrx_async_msg_framer_if bus ();

  umtrx_async_msg_framer #(.BASE(0), .DEPTH(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .set_stb  (set_stb),
    .set_addr (set_addr),
    .set_data (set_data),
    .evt_stb  (evt_stb),
    .evt_code (evt_code),
    .evt_time (evt_time),
    .src      (bus)
  );

  always #5 clk = ~clk;

`ifdef UMTRX_ASYNC_DROP_CNT_EN
  localparam logic [15:0] OVF_DROPS = 16'd2;
`else
  localparam logic [15:0] OVF_DROPS = 16'd0;
`endif

  typedef struct packed {
    logic [31:0]      code;
    logic [63:0]      t;
    logic [5:0][31:0] w;
  } vec_t;

  int          errors = 0;
  int          checks = 0;
  logic [35:0] exp_q[$];
  logic [35:0] exp_w;
  logic [3:0]  exp_seq;
  logic [31:0] sid_v;
  bit          sb_on;
  bit          hold_pend;
  logic [35:0] held;
  int          acc_cnt = 0;
  vec_t        vecs [4];
  logic [63:0] bt;
  int          acc0;
  int          nev;
  bit          ok;
  bit          found;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!sb_on) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        check("stall_valid", 64'(bus.o_valid), 64'd1);
        check("stall_data", 64'(bus.o_data), 64'(held));
      end
      if (bus.o_valid && bus.o_ready) begin
        acc_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got 0x%0h required no word", bus.o_data);
        end else begin
          exp_w = exp_q.pop_front();
          check("word", 64'(bus.o_data), 64'(exp_w));
        end
      end
      hold_pend = bus.o_valid && !bus.o_ready;
      held      = bus.o_data;
    end
  end

  function automatic vec_t mkvec(input logic [31:0] c, input logic [63:0] t,
                                 input logic [31:0] w0, input logic [31:0] w1,
                                 input logic [31:0] w2, input logic [31:0] w3,
                                 input logic [31:0] w4, input logic [31:0] w5);
    vec_t v;
    v.code = c;
    v.t    = t;
    v.w    = {w5, w4, w3, w2, w1, w0};
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_reg(input logic [7:0] a, input logic [31:0] d);
    set_stb = 1'b1; set_addr = a; set_data = d;
    tick();
    set_stb = 1'b0;
  endtask

  task automatic strobe(input logic [31:0] c, input logic [63:0] t);
    evt_stb = 1'b1; evt_code = c; evt_time = t;
    tick();
    evt_stb = 1'b0;
  endtask

  task automatic push_pkt(input logic [31:0] c, input logic [63:0] t, input logic [15:0] d);
    exp_q.push_back({4'b0001, 4'h5, 4'h0, 2'b00, 2'b01, exp_seq, 16'd6});
    exp_q.push_back({4'b0000, sid_v});
    exp_q.push_back({4'b0000, t[63:32]});
    exp_q.push_back({4'b0000, t[31:0]});
    exp_q.push_back({4'b0000, c});
    exp_q.push_back({4'b0010, 16'd0, d});
    exp_seq = exp_seq + 4'd1;
  endtask

  task automatic drain(input int bound, input string name);
    for (int i = 0; i < bound && exp_q.size() != 0; i++) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d words still pending, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic expect_quiet(input int n, input string name);
    ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick();
      if (bus.o_valid) ok = 1'b0;
    end
    check(name, 64'(ok), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; clear = 1'b0; set_stb = 1'b0; set_addr = '0; set_data = '0;
    evt_stb = 1'b0; evt_code = '0; evt_time = '0; bus.o_ready = 1'b1;
    sb_on = 1'b0; exp_seq = '0; sid_v = 32'hABCD0001;

    vecs[0] = mkvec(32'h00000004, 64'h00000001_00000020,
                    32'h50100006, 32'hABCD0001, 32'h00000001, 32'h00000020, 32'h00000004, 32'h0);
    vecs[1] = mkvec(32'h00000001, 64'hFFFFFFFF_00000000,
                    32'h50110006, 32'hABCD0001, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 32'h0);
    vecs[2] = mkvec(32'hDEADBEEF, 64'h12345678_9ABCDEF0,
                    32'h50120006, 32'hABCD0001, 32'h12345678, 32'h9ABCDEF0, 32'hDEADBEEF, 32'h0);
    vecs[3] = mkvec(32'h80000002, 64'h0,
                    32'h50130006, 32'hABCD0001, 32'h00000000, 32'h00000000, 32'h80000002, 32'h0);

    tick(); tick();
    reset = 1'b0;
    check("reset_valid", 64'(bus.o_valid), 64'd0);
    check("reset_data", 64'(bus.o_data), 64'd0);

    // enable comes out of reset cleared, so this event must vanish
    strobe(32'h1, 64'h1);
    expect_quiet(8, "reset_enable_off");

    set_reg(8'd0, sid_v);
    set_reg(8'd1, 32'h1);
    sb_on = 1'b1;

    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({4'b0001, vecs[i].w[0]});
      for (int k = 1; k < 5; k++) exp_q.push_back({4'b0000, vecs[i].w[k]});
      exp_q.push_back({4'b0010, vecs[i].w[5]});
      exp_seq = exp_seq + 4'd1;
      strobe(vecs[i].code, vecs[i].t);
      if (i == 0) begin
        check("latency_n1_valid", 64'(bus.o_valid), 64'd0);
        tick();
        check("latency_n2_valid", 64'(bus.o_valid), 64'd1);
      end
      drain(40, "table_drain");
    end

    for (int k = 0; k < 13; k++) begin
      push_pkt(32'hC0000000 + 32'(k), 64'(k), 16'd0);
      strobe(32'hC0000000 + 32'(k), 64'(k));
      repeat (9) tick();
    end
    drain(40, "wrap_drain");

    bus.o_ready = 1'b0;
    for (int k = 0; k < 5; k++)
      push_pkt(32'hE0000000 + 32'(k), {32'h0, 32'(k)}, (k == 0) ? OVF_DROPS : 16'd0);
    for (int k = 0; k < 7; k++) strobe(32'hE0000000 + 32'(k), {32'h0, 32'(k)});
    repeat (3) tick();
    check("ovf_stalled_valid", 64'(bus.o_valid), 64'd1);
    acc0 = acc_cnt;
    bus.o_ready = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check("ovf_back_to_back", 64'(acc_cnt - acc0), 64'd30);
    drain(10, "ovf_drain");

    nev = 0;
    for (int c = 0; c < 300; c++) begin
      bus.o_ready = 1'($urandom_range(0, 1));
      if ((c % 25) == 0 && nev < 8) begin
        bt = {$urandom, $urandom};
        push_pkt(32'hB0000000 + 32'(nev), bt, 16'd0);
        strobe(32'hB0000000 + 32'(nev), bt);
        nev++;
      end else begin
        tick();
      end
    end
    bus.o_ready = 1'b1;
    drain(200, "bp_drain");

    sb_on = 1'b0;
    exp_q.delete();
    strobe(32'hAAAA0000, 64'h00000777_00000001);
    strobe(32'hBBBB0000, 64'h00000888_00000002);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (bus.o_valid && bus.o_data == {4'b0000, 32'h00000777}) found = 1'b1;
      else tick();
    end
    check("abort_reached_w2", 64'(found), 64'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("abort_valid", 64'(bus.o_valid), 64'd0);
    expect_quiet(10, "abort_fifo_flushed");
    exp_seq = '0;
    sb_on = 1'b1;
    push_pkt(32'hCCCC0000, 64'h00000999_00000003, 16'd0);
    strobe(32'hCCCC0000, 64'h00000999_00000003);
    drain(40, "abort_restart_drain");

    set_reg(8'd1, 32'h0);
    for (int k = 0; k < 3; k++) strobe(32'hD0000000 + 32'(k), 64'(k));
    expect_quiet(12, "disabled_quiet");
    set_reg(8'd1, 32'h1);
    push_pkt(32'hF0000001, 64'h00000010_00000020, 16'd0);
    strobe(32'hF0000001, 64'h00000010_00000020);
    drain(40, "disabled_after_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
